bcd_ascii_tx: RTL and testbench



---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_to_ascii.sv | 15 +
 rtl/bcd_ascii_tx.sv | 178 +++++++++++++++++
 tb/tb_bcd_ascii_tx.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants for the BCD text formatters: ASCII codes, pad-mode encodings
// and the transmitter state encoding.
package bcd_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int PAD_MODE_ZERO = 0;
  localparam int PAD_MODE_CHAR = 1;
  localparam int PAD_MODE_SKIP = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_TERM = 2'd2,
    ST_DONE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/bcd_digit_to_ascii.sv
// Combinational BCD digit to ASCII byte; digits above 9 are not valid BCD and
// print as '?'.
module bcd_digit_to_ascii
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] ascii
);

  always_comb begin
    if (digit <= 4'd9) ascii = ASCII_ZERO + {4'h0, digit};
    else               ascii = ASCII_QMARK;
  end

endmodule

// File: rtl/bcd_ascii_tx.sv
// Captures a packed BCD word on load and streams it as ASCII bytes, most
// significant digit first, with leading-zero handling and an optional terminator.
//
//   state | meaning
//   IDLE  | waiting for load
//   SEND  | presenting digit bytes, index counts down to the units digit
//   TERM  | presenting TERM_CHAR
//   DONE  | one cycle, done=1, out_valid=0
module bcd_ascii_tx
  import bcd_pkg::*;
#(
  parameter int         BCD_DIGITS  = 4,
  parameter int         PAD_MODE    = 1,
  parameter logic [7:0] PAD_CHAR    = ASCII_SPACE,
  parameter bit         APPEND_TERM = 1'b1,
  parameter logic [7:0] TERM_CHAR   = ASCII_LF
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*BCD_DIGITS-1:0] bcd_in,
  output logic                    busy,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    done
);

  localparam int IW = (BCD_DIGITS > 1) ? $clog2(BCD_DIGITS) : 1;

  tx_state_t               state_q, state_d;
  logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d;
  logic [BCD_DIGITS-1:0]   lz_q, lz_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [7:0]              data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [BCD_DIGITS-1:0]   lz_in;
  logic [IW-1:0]           start_idx;
  logic [IW-1:0]           sel_idx;
  logic [4*BCD_DIGITS-1:0] sel_word;
  logic [BCD_DIGITS-1:0]   sel_lz;
  logic [3:0]              sel_digit;
  logic                    sel_is_lz;
  logic [7:0]              enc_ascii;
  logic [7:0]              byte_next;
  logic                    accept;
  logic                    any_nz;

  // Leading-zero mask of the incoming word; the units digit is never leading.
  always_comb begin
    lz_in  = '0;
    any_nz = 1'b0;
    for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
      if (bcd_in[4*i +: 4] != 4'd0) any_nz = 1'b1;
      lz_in[i] = ~any_nz;
    end
    start_idx = IW'(BCD_DIGITS - 1);
    if (PAD_MODE == PAD_MODE_SKIP) begin
      start_idx = '0;
      for (int i = 0; i < BCD_DIGITS; i++) begin
        if (!lz_in[i]) start_idx = IW'(i);
      end
    end
  end

  // The encoder sees the first digit of bcd_in while idle, otherwise the digit
  // after the one currently on the bus.
  always_comb begin
    if (state_q == ST_IDLE) begin
      sel_idx  = start_idx;
      sel_word = bcd_in;
      sel_lz   = lz_in;
    end else begin
      sel_idx  = (idx_q == '0) ? '0 : idx_q - IW'(1);
      sel_word = bcd_q;
      sel_lz   = lz_q;
    end
    sel_digit = '0;
    sel_is_lz = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (IW'(i) == sel_idx) begin
        sel_digit = sel_word[4*i +: 4];
        sel_is_lz = sel_lz[i];
      end
    end
  end

  bcd_digit_to_ascii u_enc (
    .digit (sel_digit),
    .ascii (enc_ascii)
  );

  assign byte_next = (sel_is_lz && PAD_MODE == PAD_MODE_CHAR) ? PAD_CHAR : enc_ascii;
  assign accept    = valid_q & out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      bcd_q   <= '0;
      lz_q    <= '0;
      idx_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      lz_q    <= lz_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    lz_d    = lz_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          bcd_d   = bcd_in;
          lz_d    = lz_in;
          idx_d   = start_idx;
          data_d  = byte_next;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept) begin
          if (idx_q == '0) begin
            if (APPEND_TERM) begin
              data_d  = TERM_CHAR;
              state_d = ST_TERM;
            end else begin
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            idx_d  = idx_q - IW'(1);
            data_d = byte_next;
          end
        end
      end
      ST_TERM: begin
        if (accept) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bcd_ascii_tx.sv
// Directed bench for bcd_ascii_tx: one instance per leading-zero mode, all with
// the LF terminator, sharing clock, reset, bcd_in and out_ready.
module tb_bcd_ascii_tx;

  typedef logic [7:0] bq_t[$];

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] bcd_in = '0;
  logic        out_ready = 1'b1;
  logic        ld [3];
  logic [7:0]  od [3];
  logic        ov [3];
  logic        bz [3];
  logic        dn [3];

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  bcd_ascii_tx #(.BCD_DIGITS(4), .PAD_MODE(0), .PAD_CHAR(8'h20), .APPEND_TERM(1'b1), .TERM_CHAR(8'h0A)) u_m0 (
    .clock(clock), .reset_n(reset_n), .load(ld[0]), .bcd_in(bcd_in), .busy(bz[0]),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .done(dn[0]));
  bcd_ascii_tx #(.BCD_DIGITS(4), .PAD_MODE(1), .PAD_CHAR(8'h20), .APPEND_TERM(1'b1), .TERM_CHAR(8'h0A)) u_m1 (
    .clock(clock), .reset_n(reset_n), .load(ld[1]), .bcd_in(bcd_in), .busy(bz[1]),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .done(dn[1]));
  bcd_ascii_tx #(.BCD_DIGITS(4), .PAD_MODE(2), .PAD_CHAR(8'h20), .APPEND_TERM(1'b1), .TERM_CHAR(8'h0A)) u_m2 (
    .clock(clock), .reset_n(reset_n), .load(ld[2]), .bcd_in(bcd_in), .busy(bz[2]),
    .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready), .done(dn[2]));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Load one word into instance k with out_ready held high and check every byte,
  // then the done pulse and its clearing.
  task automatic run_frame(input int k, input logic [15:0] w, input bq_t exp);
    bcd_in = w;
    ld[k]  = 1'b1;
    tick();
    ld[k]  = 1'b0;
    for (int i = 0; i < exp.size(); i++) begin
      chk($sformatf("m%0d_%h_valid%0d", k, w, i), {7'd0, ov[k]}, 8'd1);
      chk($sformatf("m%0d_%h_byte%0d", k, w, i), od[k], exp[i]);
      chk($sformatf("m%0d_%h_busy%0d", k, w, i), {7'd0, bz[k]}, 8'd1);
      tick();
    end
    chk($sformatf("m%0d_%h_done", k, w), {7'd0, dn[k]}, 8'd1);
    chk($sformatf("m%0d_%h_valid_end", k, w), {7'd0, ov[k]}, 8'd0);
    chk($sformatf("m%0d_%h_busy_end", k, w), {7'd0, bz[k]}, 8'd0);
    tick();
    chk($sformatf("m%0d_%h_done_clr", k, w), {7'd0, dn[k]}, 8'd0);
  endtask

  initial begin
    bq_t q;
    logic pat [12];
    int e;
    int cyc;

    ld[0] = 1'b0; ld[1] = 1'b0; ld[2] = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_valid_m%0d", k), {7'd0, ov[k]}, 8'd0);
      chk($sformatf("rst_busy_m%0d", k), {7'd0, bz[k]}, 8'd0);
      chk($sformatf("rst_done_m%0d", k), {7'd0, dn[k]}, 8'd0);
      chk($sformatf("rst_data_m%0d", k), od[k], 8'h00);
    end
    tick(); tick();
    reset_n = 1'b1;
    tick();

    q = '{8'h30, 8'h30, 8'h34, 8'h32, 8'h0A};
    run_frame(0, 16'h0042, q);

    q = '{8'h20, 8'h20, 8'h20, 8'h37, 8'h0A};
    run_frame(1, 16'h0007, q);
    q = '{8'h20, 8'h20, 8'h20, 8'h30, 8'h0A};
    run_frame(1, 16'h0000, q);

    q = '{8'h31, 8'h30, 8'h35, 8'h0A};
    run_frame(2, 16'h0105, q);
    q = '{8'h30, 8'h0A};
    run_frame(2, 16'h0000, q);

    q = '{8'h3F, 8'h33, 8'h0A};
    run_frame(2, 16'h00A3, q);

    // Backpressure with a stray load mid-frame and another during DONE.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    q = '{8'h30, 8'h31, 8'h31, 8'h30, 8'h0A};
    bcd_in = 16'h0110;
    ld[0]  = 1'b1;
    tick();
    ld[0]  = 1'b0;
    e   = 0;
    cyc = 0;
    while (e < 5 && cyc < 12) begin
      out_ready = pat[cyc];
      if (cyc == 2) begin
        bcd_in = 16'h9999;
        ld[0]  = 1'b1;
      end else begin
        ld[0]  = 1'b0;
      end
      chk($sformatf("bp_valid_c%0d", cyc), {7'd0, ov[0]}, 8'd1);
      chk($sformatf("bp_byte_c%0d", cyc), od[0], q[e]);
      tick();
      if (pat[cyc]) e++;
      cyc++;
    end
    ld[0] = 1'b0;
    chk("bp_all_bytes_within_budget", e[7:0], 8'd5);
    chk("bp_done", {7'd0, dn[0]}, 8'd1);
    chk("bp_valid_end", {7'd0, ov[0]}, 8'd0);
    bcd_in = 16'h9999;
    ld[0]  = 1'b1;
    tick();
    ld[0]  = 1'b0;
    chk("load_in_done_ignored_valid", {7'd0, ov[0]}, 8'd0);
    chk("load_in_done_ignored_busy", {7'd0, bz[0]}, 8'd0);
    out_ready = 1'b1;
    tick();

    // Reset mid-frame, after two bytes have been accepted.
    bcd_in = 16'h1234;
    ld[0]  = 1'b1;
    tick();
    ld[0]  = 1'b0;
    chk("rstmid_byte0", od[0], 8'h31);
    tick();
    chk("rstmid_byte1", od[0], 8'h32);
    tick();
    reset_n = 1'b0;
    #1;
    chk("rstmid_valid", {7'd0, ov[0]}, 8'd0);
    chk("rstmid_busy", {7'd0, bz[0]}, 8'd0);
    chk("rstmid_done", {7'd0, dn[0]}, 8'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rstmid_no_resume", {7'd0, ov[0]}, 8'd0);
    q = '{8'h30, 8'h30, 8'h39, 8'h39, 8'h0A};
    run_frame(0, 16'h0099, q);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
